// File: rtl/dev_cnt_intc_pkg.sv
// rtl/dev_cnt_intc_pkg.sv - register map and bit positions for the interrupt controller
package dev_cnt_intc_pkg;

   typedef enum logic [2:0] {
      OFS_PEND   = 3'd0,
      OFS_MASK   = 3'd1,
      OFS_VEC    = 3'd2,
      OFS_EOI    = 3'd3,
      OFS_CTRL   = 3'd4,
      OFS_INSERV = 3'd5
   } reg_ofs_e;

   localparam logic [15:0] NUM_REGS      = 16'd6;
   localparam int          CTRL_GEN      = 0;
   localparam int          CTRL_ROT      = 1;
   localparam int          VEC_VALID_BIT = 15;

endpackage

// File: rtl/dev_cnt_intc_if.sv
// rtl/dev_cnt_intc_if.sv - CPU-side address/write bus of the PICO16a device space
interface dev_cnt_intc_if;
   logic [15:0] adrs;
   logic [15:0] from_cpu;
   logic        we;

   modport master (output adrs, from_cpu, we);
   modport slave  (input  adrs, from_cpu, we);
endinterface

// File: rtl/dev_cnt_intc_prio_pick.sv
// rtl/dev_cnt_intc_prio_pick.sv - rotating priority encoder: first set bit at or after start
module dev_cnt_intc_prio_pick #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic         valid,
   output logic [W-1:0] idx,
   output logic [W-1:0] pos
);
   localparam logic [W:0] N_W = (W+1)'(N);

   logic [2*N-1:0] shifted;
   logic [N-1:0]   rotated;
   logic           unused_hi;

   // rotated[k] is the source k steps after start in search order
   assign shifted   = {vec, vec} >> start;
   assign rotated   = shifted[N-1:0];
   assign unused_hi = ^shifted[2*N-1:N];

   always_comb begin
      logic [W:0] sum;
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      sum   = '0;
      for (int k = N-1; k >= 0; k--) begin
         if (rotated[k]) begin
            sum = {1'b0, start} + (W+1)'(k);
            if (sum >= N_W) sum = sum - N_W;
            valid = 1'b1;
            idx   = sum[W-1:0];
            pos   = W'(k);
         end
      end
   end
endmodule

// File: rtl/dev_cnt_intc.sv
// rtl/dev_cnt_intc.sv - prioritised, maskable, nesting interrupt controller on the PICO16a bus
module dev_cnt_intc
   import dev_cnt_intc_pkg::*;
#(
   parameter logic [15:0] BASE_ADRS = 16'hFF40,
   parameter int          NUM_SRC   = 4,
   parameter int          IDW       = 2
) (
   input  logic               cpu_clk,
   input  logic               rst,
   dev_cnt_intc_if.slave      bus,
   output logic [15:0]        to_cpu,
   input  logic [NUM_SRC-1:0] src,
   output logic               int_req
);
   localparam logic [IDW:0] NUM_W = (IDW+1)'(NUM_SRC);

   logic [NUM_SRC-1:0] sync1, sync2, sync3;
   logic [NUM_SRC-1:0] pend, mask, inserv;
   logic [1:0]         ctrl;
   logic [IDW-1:0]     rr_ptr;

   logic [15:0]        off;
   logic               hit, wr;
   reg_ofs_e           sel;
   logic [NUM_SRC-1:0] cand, pend_clr, ins_set, ins_clr;
   logic [IDW-1:0]     start, best_idx, best_pos, ins_idx, ins_pos;
   logic               best_valid, ins_valid, preempt, claim;
   logic [IDW:0]       rr_inc;
   logic [15:0]        rdata;
   logic               unused_bits;

   assign off   = bus.adrs - BASE_ADRS;
   assign hit   = off < NUM_REGS;
   assign wr    = hit & bus.we;
   assign sel   = reg_ofs_e'(off[2:0]);
   assign cand  = pend & mask;
   assign start = ctrl[CTRL_ROT] ? rr_ptr : '0;

   dev_cnt_intc_prio_pick #(.N(NUM_SRC), .W(IDW)) u_pick_cand (
      .vec(cand), .start(start), .valid(best_valid), .idx(best_idx), .pos(best_pos)
   );
   dev_cnt_intc_prio_pick #(.N(NUM_SRC), .W(IDW)) u_pick_ins (
      .vec(inserv), .start(start), .valid(ins_valid), .idx(ins_idx), .pos(ins_pos)
   );

   // both positions are measured from the same start, so a smaller one means higher priority
   assign preempt = ~ins_valid | (best_pos < ins_pos);
   assign claim   = wr & (sel == OFS_VEC) & best_valid;

   always_comb begin
      pend_clr = '0;
      ins_set  = '0;
      ins_clr  = '0;
      rr_inc   = {1'b0, best_idx} + 1'b1;
      if (rr_inc >= NUM_W) rr_inc = '0;
      if (wr && sel == OFS_PEND) pend_clr = bus.from_cpu[NUM_SRC-1:0];
      if (claim) begin
         pend_clr = NUM_SRC'(1) << best_idx;
         ins_set  = NUM_SRC'(1) << best_idx;
      end
      if (wr && sel == OFS_EOI) ins_clr = NUM_SRC'(1) << bus.from_cpu[IDW-1:0];
   end

   always_ff @(posedge cpu_clk or negedge rst) begin
      if (!rst) begin
         sync1   <= '0;
         sync2   <= '0;
         sync3   <= '0;
         pend    <= '0;
         mask    <= '0;
         inserv  <= '0;
         ctrl    <= '0;
         rr_ptr  <= '0;
         int_req <= 1'b0;
      end else begin
         sync1   <= src;
         sync2   <= sync1;
         sync3   <= sync2;
         // a fresh edge overrides a same-cycle clear
         pend    <= (pend & ~pend_clr) | (sync2 & ~sync3);
         inserv  <= (inserv & ~ins_clr) | ins_set;
         if (wr && sel == OFS_MASK) mask <= bus.from_cpu[NUM_SRC-1:0];
         if (wr && sel == OFS_CTRL) ctrl <= bus.from_cpu[1:0];
         if (claim && ctrl[CTRL_ROT]) rr_ptr <= rr_inc[IDW-1:0];
         int_req <= ctrl[CTRL_GEN] & best_valid & preempt;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         OFS_PEND:   rdata[NUM_SRC-1:0] = pend;
         OFS_MASK:   rdata[NUM_SRC-1:0] = mask;
         OFS_VEC: begin
            rdata[VEC_VALID_BIT] = best_valid;
            rdata[IDW-1:0]       = best_valid ? best_idx : '0;
         end
         OFS_CTRL:   rdata[1:0] = ctrl;
         OFS_INSERV: rdata[NUM_SRC-1:0] = inserv;
         default:    rdata = '0;
      endcase
   end

   assign to_cpu      = (hit && !bus.we) ? rdata : 16'hzzzz;
   assign unused_bits = ^{bus.from_cpu, ins_idx};
endmodule
